// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA timing constants (640x480@60), RGB565 colours and
//                small helpers used by the timing generator and data stage.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

  // 640x480@60 timing, pclk 25.175 MHz
  localparam int H_SYNC_640  = 96;
  localparam int H_BACK_640  = 48;
  localparam int H_ADDR_640  = 640;
  localparam int H_FRONT_640 = 16;
  localparam int V_SYNC_640  = 2;
  localparam int V_BACK_640  = 33;
  localparam int V_ADDR_640  = 480;
  localparam int V_FRONT_640 = 10;

  localparam int H_TOTAL_640 = H_SYNC_640 + H_BACK_640 + H_ADDR_640 + H_FRONT_640;
  localparam int V_TOTAL_640 = V_SYNC_640 + V_BACK_640 + V_ADDR_640 + V_FRONT_640;

  // RGB565 colours shared with the pattern/data stage
  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;

  // Bundle of the three control signals carried through the delay line
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_bus_t;

  // Idle (reset) value of the sync bundle: syncs inactive, de low
  function automatic logic [2:0] sync_idle(input logic pol);
    return {~pol, ~pol, 1'b0};
  endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/sync_delay.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sync_delay
//  Description : Parameterised-depth shift register with per-bit reset value.
//                DEPTH = 0 collapses to a straight wire.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Clock and reset are not needed when there is no storage
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stages [DEPTH];

      // Shift the bundle one stage per clock; reset loads the idle pattern
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stages[i] <= RST_VAL;
          end
        end else begin
          stages[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
          end
        end
      end

      assign q = stages[DEPTH-1];
    end
  endgenerate

endmodule : sync_delay
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Free-running VGA raster timing generator. Registered hsync,
//                vsync, de, active-area X/Y and frame_start, plus copies of
//                hsync/vsync/de delayed DATA_LAT cycles for data alignment.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_640,
  parameter int H_BACK   = H_BACK_640,
  parameter int H_ADDR   = H_ADDR_640,
  parameter int H_FRONT  = H_FRONT_640,
  parameter int V_SYNC   = V_SYNC_640,
  parameter int V_BACK   = V_BACK_640,
  parameter int V_ADDR   = V_ADDR_640,
  parameter int V_FRONT  = V_FRONT_640,
  parameter bit SYNC_POL = 1'b0,
  parameter int DATA_LAT = 1
) (
  input  logic       pclk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       frame_start,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       de_o
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ADDR + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ADDR + V_FRONT;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_ADDR);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_ADDR);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;

  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       de_nxt;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       fs_nxt;

  sync_bus_t  bus_now;
  sync_bus_t  bus_dly;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Raster counters: h wraps every line, v advances on the h wrap edge
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Decode the current counter values into next-cycle output values
  always_comb begin
    hsync_nxt = ~SYNC_POL;
    vsync_nxt = ~SYNC_POL;
    de_nxt    = 1'b0;
    x_nxt     = '0;
    y_nxt     = '0;
    fs_nxt    = 1'b0;

    if (h_cnt < H_SYNC_END) hsync_nxt = SYNC_POL;
    if (v_cnt < V_SYNC_END) vsync_nxt = SYNC_POL;

    de_nxt = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END) &&
             (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);

    if (de_nxt) begin
      x_nxt  = h_cnt - H_ACT_START;
      y_nxt  = v_cnt - V_ACT_START;
      fs_nxt = (h_cnt == H_ACT_START) && (v_cnt == V_ACT_START);
    end
  end

  // Output register stage: outputs lag the counters by one cycle
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      X           <= '0;
      Y           <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      de          <= de_nxt;
      X           <= x_nxt;
      Y           <= y_nxt;
      frame_start <= fs_nxt;
    end
  end

  assign bus_now.hsync = hsync;
  assign bus_now.vsync = vsync;
  assign bus_now.de    = de;

  // Align control signals with the downstream data-stage latency
  sync_delay #(
    .WIDTH   (3),
    .DEPTH   (DATA_LAT),
    .RST_VAL (sync_idle(SYNC_POL))
  ) u_sync_delay (
    .clk   (pclk),
    .rst_n (rst_n),
    .d     (bus_now),
    .q     (bus_dly)
  );

  assign hsync_o = bus_dly.hsync;
  assign vsync_o = bus_dly.vsync;
  assign de_o    = bus_dly.de;

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. One instance in the
//                default 640x480 mode checked against a table of hand-derived
//                vectors; three small-raster instances (different DATA_LAT and
//                SYNC_POL) checked every cycle against an elapsed-time model
//                while random asynchronous resets are applied.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  // Small raster: 17 x 10 = 170 cycles per frame
  localparam int S_HS = 4, S_HB = 3, S_HA = 8, S_HF = 2;
  localparam int S_VS = 2, S_VB = 2, S_VA = 5, S_VF = 1;
  localparam int S_HT = S_HS + S_HB + S_HA + S_HF;
  localparam int S_VT = S_VS + S_VB + S_VA + S_VF;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
  } out_t;

  typedef struct {
    int         k;
    logic       hs, vs, de;
    logic [9:0] x, y;
    logic       fs, hso, vso, deo;
  } vec_t;

  logic pclk = 1'b0;
  logic rst_def_n = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;

  int cnt_cmp = 0;
  int cnt_bad = 0;
  int k_def;
  int k_s;

  always #5 pclk = ~pclk;

  // Default-mode DUT
  logic       hs_d, vs_d, de_d, fs_d, hso_d, vso_d, deo_d;
  logic [9:0] x_d, y_d;

  vga_timing_gen u_def (
    .pclk(pclk), .rst_n(rst_def_n), .hsync(hs_d), .vsync(vs_d), .de(de_d),
    .X(x_d), .Y(y_d), .frame_start(fs_d),
    .hsync_o(hso_d), .vsync_o(vso_d), .de_o(deo_d)
  );

  // Small-raster DUTs: A (lat 1, active-low), B (lat 3, active-high), C (lat 0)
  logic       hs_a, vs_a, de_a, fs_a, hso_a, vso_a, deo_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, de_b, fs_b, hso_b, vso_b, deo_b;
  logic [9:0] x_b, y_b;
  logic       hs_c, vs_c, de_c, fs_c, hso_c, vso_c, deo_c;
  logic [9:0] x_c, y_c;

  vga_timing_gen #(
    .H_SYNC(S_HS), .H_BACK(S_HB), .H_ADDR(S_HA), .H_FRONT(S_HF),
    .V_SYNC(S_VS), .V_BACK(S_VB), .V_ADDR(S_VA), .V_FRONT(S_VF),
    .SYNC_POL(1'b0), .DATA_LAT(1)
  ) u_a (
    .pclk(pclk), .rst_n(rst_n), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .X(x_a), .Y(y_a), .frame_start(fs_a),
    .hsync_o(hso_a), .vsync_o(vso_a), .de_o(deo_a)
  );

  vga_timing_gen #(
    .H_SYNC(S_HS), .H_BACK(S_HB), .H_ADDR(S_HA), .H_FRONT(S_HF),
    .V_SYNC(S_VS), .V_BACK(S_VB), .V_ADDR(S_VA), .V_FRONT(S_VF),
    .SYNC_POL(1'b1), .DATA_LAT(3)
  ) u_b (
    .pclk(pclk), .rst_n(rst_n), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .X(x_b), .Y(y_b), .frame_start(fs_b),
    .hsync_o(hso_b), .vsync_o(vso_b), .de_o(deo_b)
  );

  vga_timing_gen #(
    .H_SYNC(S_HS), .H_BACK(S_HB), .H_ADDR(S_HA), .H_FRONT(S_HF),
    .V_SYNC(S_VS), .V_BACK(S_VB), .V_ADDR(S_VA), .V_FRONT(S_VF),
    .SYNC_POL(1'b0), .DATA_LAT(0)
  ) u_c (
    .pclk(pclk), .rst_n(rst_n), .hsync(hs_c), .vsync(vs_c), .de(de_c),
    .X(x_c), .Y(y_c), .frame_start(fs_c),
    .hsync_o(hso_c), .vsync_o(vso_c), .de_o(deo_c)
  );

  // Count clock edges since each reset release
  always @(posedge pclk or negedge rst_def_n) begin
    if (!rst_def_n) k_def <= 0;
    else            k_def <= k_def + 1;
  end

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) k_s <= 0;
    else        k_s <= k_s + 1;
  end

  // Expected small-raster outputs after k edges since reset release.
  // The edge k shows the decode of raster position k-1 of the free-running scan.
  function automatic out_t model_s(input int k, input bit pol);
    out_t o;
    int   n, h, v;
    bit   in_h, in_v;
    o    = '0;
    o.hs = ~pol;
    o.vs = ~pol;
    if (k >= 1) begin
      n    = (k - 1) % (S_HT * S_VT);
      h    = n % S_HT;
      v    = n / S_HT;
      o.hs = (h < S_HS) ? pol : ~pol;
      o.vs = (v < S_VS) ? pol : ~pol;
      in_h = (h >= S_HS + S_HB) && (h < S_HS + S_HB + S_HA);
      in_v = (v >= S_VS + S_VB) && (v < S_VS + S_VB + S_VA);
      o.de = in_h && in_v;
      if (o.de) begin
        o.x = 10'(h - (S_HS + S_HB));
        o.y = 10'(v - (S_VS + S_VB));
      end
      o.fs = o.de && (o.x == 10'd0) && (o.y == 10'd0);
    end
    return o;
  endfunction

  function automatic logic [2:0] dly_s(input int k, input int lat, input bit pol);
    out_t o;
    o = model_s(k - lat, pol);
    return {o.hs, o.vs, o.de};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cnt_cmp++;
    if (act !== exp) begin
      cnt_bad++;
      if (cnt_bad <= 30)
        $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the small-raster instances against the model
  always @(negedge pclk) begin
    if (chk_en) begin
      check($sformatf("A main k=%0d", k_s), 64'({hs_a, vs_a, de_a, x_a, y_a, fs_a}), 64'(model_s(k_s, 1'b0)));
      check($sformatf("A dly k=%0d", k_s),  64'({hso_a, vso_a, deo_a}), 64'(dly_s(k_s, 1, 1'b0)));
      check($sformatf("B main k=%0d", k_s), 64'({hs_b, vs_b, de_b, x_b, y_b, fs_b}), 64'(model_s(k_s, 1'b1)));
      check($sformatf("B dly k=%0d", k_s),  64'({hso_b, vso_b, deo_b}), 64'(dly_s(k_s, 3, 1'b1)));
      check($sformatf("C main k=%0d", k_s), 64'({hs_c, vs_c, de_c, x_c, y_c, fs_c}), 64'(model_s(k_s, 1'b0)));
      check($sformatf("C dly k=%0d", k_s),  64'({hso_c, vso_c, deo_c}), 64'(dly_s(k_s, 0, 1'b0)));
    end
  end

  vec_t tbl[17];

  initial begin
    // k, hs, vs, de, X, Y, fs, hs_o, vs_o, de_o  (default mode, DATA_LAT=1)
    tbl[0]  = '{0,     1, 1, 0, 10'd0,   10'd0, 0, 1, 1, 0};  // held in reset
    tbl[1]  = '{1,     0, 0, 0, 10'd0,   10'd0, 0, 1, 1, 0};  // first edge: syncs active
    tbl[2]  = '{2,     0, 0, 0, 10'd0,   10'd0, 0, 0, 0, 0};  // delayed syncs follow
    tbl[3]  = '{96,    0, 0, 0, 10'd0,   10'd0, 0, 0, 0, 0};  // last hsync cycle
    tbl[4]  = '{97,    1, 0, 0, 10'd0,   10'd0, 0, 0, 0, 0};  // hsync returns high
    tbl[5]  = '{98,    1, 0, 0, 10'd0,   10'd0, 0, 1, 0, 0};
    tbl[6]  = '{801,   0, 0, 0, 10'd0,   10'd0, 0, 1, 0, 0};  // 800-cycle h period
    tbl[7]  = '{1600,  1, 0, 0, 10'd0,   10'd0, 0, 1, 0, 0};  // last vsync cycle
    tbl[8]  = '{1601,  0, 1, 0, 10'd0,   10'd0, 0, 1, 0, 0};  // vsync high after 1600
    tbl[9]  = '{1602,  0, 1, 0, 10'd0,   10'd0, 0, 0, 1, 0};
    tbl[10] = '{28145, 1, 1, 1, 10'd0,   10'd0, 1, 1, 1, 0};  // first active pixel
    tbl[11] = '{28146, 1, 1, 1, 10'd1,   10'd0, 0, 1, 1, 1};
    tbl[12] = '{28784, 1, 1, 1, 10'd639, 10'd0, 0, 1, 1, 1};  // last pixel of line
    tbl[13] = '{28785, 1, 1, 0, 10'd0,   10'd0, 0, 1, 1, 1};
    tbl[14] = '{28786, 1, 1, 0, 10'd0,   10'd0, 0, 1, 1, 0};
    tbl[15] = '{28945, 1, 1, 1, 10'd0,   10'd1, 0, 1, 1, 0};  // second active line
    tbl[16] = '{28946, 1, 1, 1, 10'd1,   10'd1, 0, 1, 1, 1};

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk_en    = 1'b1;
    rst_def_n = 1'b1;
    rst_n     = 1'b1;

    // Table-driven checks on the default-mode instance
    for (int i = 0; i < 17; i++) begin
      int guard;
      guard = 0;
      while (k_def < tbl[i].k && guard < 40000) begin
        @(negedge pclk);
        guard++;
      end
      check($sformatf("table[%0d] k=%0d", i, tbl[i].k),
            64'({hs_d, vs_d, de_d, x_d, y_d, fs_d, hso_d, vso_d, deo_d}),
            64'({tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].x, tbl[i].y,
                 tbl[i].fs, tbl[i].hso, tbl[i].vso, tbl[i].deo}));
    end

    // Random asynchronous resets on the small-raster instances
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(1, 400)) @(posedge pclk);
      #2 rst_n = 1'b0;
      #1;
      check($sformatf("A async rst %0d", r), 64'({hs_a, vs_a, de_a, x_a, y_a, fs_a, hso_a, vso_a, deo_a}),
            64'({model_s(0, 1'b0), 3'b110}));
      check($sformatf("B async rst %0d", r), 64'({hs_b, vs_b, de_b, x_b, y_b, fs_b, hso_b, vso_b, deo_b}),
            64'({model_s(0, 1'b1), 3'b000}));
      check($sformatf("C async rst %0d", r), 64'({hs_c, vs_c, de_c, x_c, y_c, fs_c, hso_c, vso_c, deo_c}),
            64'({model_s(0, 1'b0), 3'b110}));
      repeat ($urandom_range(1, 5)) @(posedge pclk);
      @(negedge pclk);
      rst_n = 1'b1;
    end

    // Let the last restart run past a full frame
    repeat (400) @(posedge pclk);
    @(negedge pclk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
    $finish;
  end

endmodule : tb_vga_timing_gen
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing on the pixel clock.
- Produces hsync, vsync, de and active-area pixel coordinates X/Y that drive the pattern/data stage directly downstream.
- Also provides copies of hsync/vsync/de delayed by a parameterised number of cycles. These line up with the pixel data the downstream stage emits after its own register latency.
- Default mode: 640x480@60, pclk 25.175 MHz.

Parameters:
- H_SYNC, 96, hsync pulse width in pclk cycles
- H_BACK, 48, horizontal back porch
- H_ADDR, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch
- V_ADDR, 480, active lines per frame
- V_FRONT, 10, vertical front porch
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- DATA_LAT, 1, delay in cycles applied to hsync_o/vsync_o/de_o; legal range 0..4

Ports:
- pclk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- hsync  output  1  horizontal sync, registered
- vsync  output  1  vertical sync, registered
- de  output  1  active-video enable, registered
- X  output  10  active-area column, 0..H_ADDR-1; 0 when de=0
- Y  output  10  active-area row, 0..V_ADDR-1; 0 when de=0
- frame_start  output  1  one-cycle pulse coincident with de=1 at X=0, Y=0
- hsync_o  output  1  hsync delayed DATA_LAT cycles
- vsync_o  output  1  vsync delayed DATA_LAT cycles
- de_o  output  1  de delayed DATA_LAT cycles

Behaviour:
- Single clock pclk. Reset is asynchronous, active-low (rst_n).
- H_TOTAL = H_SYNC+H_BACK+H_ADDR+H_FRONT (800). V_TOTAL = V_SYNC+V_BACK+V_ADDR+V_FRONT (525).
- Horizontal counter h_cnt, 10 bits:
  - 0..H_TOTAL-1, increments every pclk.
  - At H_TOTAL-1 it wraps to 0, and v_cnt advances on that same edge.
- Vertical counter v_cnt, 10 bits:
  - 0..V_TOTAL-1.
  - Wraps to 0 when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 on the same edge.
- Region order per axis: sync, back porch, active, front porch, starting at count 0.
- Registered decode of the current counter values (outputs lag counters by 1 cycle):
  - hsync = SYNC_POL when h_cnt < H_SYNC, else ~SYNC_POL.
  - vsync is the same rule on v_cnt.
  - de = 1 iff H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ADDR and the equivalent V condition holds.
  - X = h_cnt-(H_SYNC+H_BACK), Y = v_cnt-(V_SYNC+V_BACK) when the de condition is true; both 0 otherwise.
  - frame_start = 1 iff the de condition holds with X=0 and Y=0.
- Reset values:
  - h_cnt, v_cnt = 0.
  - hsync, vsync = ~SYNC_POL.
  - de, X, Y, frame_start = 0.
  - All delay-line stages: sync taps = ~SYNC_POL, de taps = 0.
- First edge after reset release: hsync and vsync go active (counters at 0,0). First de=1 appears at h_cnt=144, v_cnt=35 decode.
- Delay line:
  - hsync_o/vsync_o/de_o equal hsync/vsync/de delayed exactly DATA_LAT pclk edges.
  - DATA_LAT=0 gives direct wires.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). The frame restarts from count 0,0 on release; no partial-frame recovery.
- No input handshake; the block is free-running.

Decomposition:
- Shared package vga_pkg holds:
  - timing constants for 640x480@60 and their H_TOTAL/V_TOTAL derivations;
  - RGB565 colour constants shared with the data stage.
- One sub-module, sync_delay: a parameterised-depth shift register, width 3, with reset values per bit. It is used for the DATA_LAT alignment.

Test Plan:
- Reset release, default params:
  - First edge: hsync=0, vsync=0, de=0.
  - hsync returns high after 96 cycles.
  - hsync period is 800 cycles.
- Active window:
  - de rises at h decode 144, line 35 of each frame, with X=0, Y=0 and frame_start=1 for exactly one cycle.
  - X reaches 639 on the last de cycle of the line; de is high 640 consecutive cycles per active line.
- Frame wrap:
  - vsync low for exactly 2×800=1600 cycles.
  - Frame period is 800×525=420000 cycles.
  - Exactly 480 lines contain de=1.
- DATA_LAT=1 and DATA_LAT=3: de_o equals de shifted 1 and 3 cycles respectively. hsync_o/vsync_o match likewise, including across the line and frame wrap.
- SYNC_POL=1: hsync/vsync are active-high with identical timing, and reset value is 0.
- Reset asserted at h_cnt=400, v_cnt=200:
  - Outputs go to reset values asynchronously, before the next edge.
  - After release, timing matches the fresh-reset case cycle for cycle.
